// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-side memory responder.
// Used by data_mem_responder and dmem_mmio (MMIO window enabled by DMEM_MMIO_EN).
package dmem_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        MS_NONE = 2'b00,
        MS_BYTE = 2'b01,
        MS_HALF = 2'b10,
        MS_WORD = 2'b11
    } memsize_e;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_MMIO = 2'd1,
        REG_NONE = 2'd2
    } region_e;

    localparam logic [15:0] OFF_GPIO = 16'h0000;
    localparam logic [15:0] OFF_MTLO = 16'h0004;
    localparam logic [15:0] OFF_MTHI = 16'h0008;
    localparam logic [15:0] OFF_STAT = 16'h000C;

    typedef struct packed {
        logic            write;
        logic            load;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        memsize_e        size;
    } dmem_req_t;

    // Byte lanes touched by an access of the given size starting at lane off
    function automatic logic [3:0] lane_mask(input memsize_e size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            MS_BYTE: m = 4'b0001 << off;
            MS_HALF: m = 4'b0011 << off;
            MS_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Right-aligned data mask for a read of the given size
    function automatic logic [XLEN-1:0] size_mask(input memsize_e size);
        logic [XLEN-1:0] m;
        case (size)
            MS_BYTE: m = 32'h0000_00FF;
            MS_HALF: m = 32'h0000_FFFF;
            MS_WORD: m = 32'hFFFF_FFFF;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_mmio.sv
// MMIO register block: GPIO_OUT, free-running 64-bit mtime, MTIME_HI shadow, STATUS clear.
// Instantiated by data_mem_responder only when DMEM_MMIO_EN is defined.
module dmem_mmio
    import dmem_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            acc,
    input  logic            write,
    input  logic            load,
    input  logic [15:0]     offset,
    input  logic [XLEN-1:0] wdata,
    input  logic            err,
    output logic [XLEN-1:0] rdata_c,
    output logic            err_clr_c,
    output logic [XLEN-1:0] gpio
);

    logic [63:0]     mtime;
    logic [XLEN-1:0] mtime_hi_shadow;

    // Timer runs every cycle; a load of MTIME_LO snapshots the upper half for a coherent 64-bit read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime           <= 64'd0;
            mtime_hi_shadow <= '0;
            gpio            <= '0;
        end else begin
            mtime <= mtime + 64'd1;
            if (acc && write && offset == OFF_GPIO) begin
                gpio <= wdata;
            end
            if (acc && load && offset == OFF_MTLO) begin
                mtime_hi_shadow <= mtime[63:32];
            end
        end
    end

    always_comb begin
        rdata_c = '0;
        if (acc && load) begin
            case (offset)
                OFF_GPIO: rdata_c = gpio;
                OFF_MTLO: rdata_c = mtime[31:0];
                OFF_MTHI: rdata_c = mtime_hi_shadow;
                OFF_STAT: rdata_c = {31'd0, err};
                default:  rdata_c = '0;
            endcase
        end
    end

    assign err_clr_c = acc && write && (offset == OFF_STAT) && wdata[0];

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder for the single-cycle RV32 core: zero-latency reads, byte-lane stores,
// sticky access-error flag, and an optional MMIO window enabled by defining DMEM_MMIO_EN.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter string       INIT_FILE   = "",
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_write,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_data,
    input  logic [1:0]      i_memsize,
    output logic [XLEN-1:0] o_data,
    output logic            o_err,
    output logic [XLEN-1:0] o_gpio
);

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    dmem_req_t       req;
    region_e         region;
    logic [1:0]      off;
    logic [AW-1:0]   idx;
    logic            valid;
    logic            aligned;
    logic            ram_ok;
    logic            mmio_ok;
    logic            err_ev;
    logic            err_clr;
    logic            err_q;
    logic [3:0]      lanes;
    logic [XLEN-1:0] ram_word;
    logic [XLEN-1:0] ram_rdata;
    logic [XLEN-1:0] wdata_sh;
    logic [XLEN-1:0] mmio_rdata;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    assign req = '{write: i_write, load: i_load, addr: i_addr, data: i_data,
                   size: memsize_e'(i_memsize)};

    // Region decode and alignment; RAM takes priority over the MMIO page
    always_comb begin
        valid   = req.write || req.load;
        off     = req.addr[1:0];
        idx     = req.addr[AW+1:2];
        region  = REG_NONE;
        aligned = 1'b0;
        if ({1'b0, req.addr} < RAM_BYTES) begin
            region = REG_RAM;
        end else if (req.addr[31:16] == MMIO_BASE[31:16]) begin
            region = REG_MMIO;
        end
        case (req.size)
            MS_BYTE: aligned = 1'b1;
            MS_HALF: aligned = !off[0];
            MS_WORD: aligned = (off == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

`ifdef DMEM_MMIO_EN
    always_comb begin
        mmio_ok = (region == REG_MMIO) && (req.size == MS_WORD) &&
                  (req.addr[15:0] == OFF_GPIO || req.addr[15:0] == OFF_MTLO ||
                   req.addr[15:0] == OFF_MTHI || req.addr[15:0] == OFF_STAT);
    end

    dmem_mmio u_mmio (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .acc       (mmio_ok),
        .write     (req.write),
        .load      (req.load),
        .offset    (req.addr[15:0]),
        .wdata     (req.data),
        .err       (err_q),
        .rdata_c   (mmio_rdata),
        .err_clr_c (err_clr),
        .gpio      (o_gpio)
    );
`else
    assign mmio_ok    = 1'b0;
    assign mmio_rdata = '0;
    assign err_clr    = 1'b0;
    assign o_gpio     = '0;
`endif

    assign ram_ok = (region == REG_RAM) && aligned;
    assign err_ev = valid && !(ram_ok || mmio_ok);

    // Read path shows pre-write contents even when a store hits the same word this cycle
    always_comb begin
        ram_word  = mem[idx];
        ram_rdata = (ram_word >> {off, 3'b000}) & size_mask(req.size);
        lanes     = lane_mask(req.size, off);
        wdata_sh  = req.data << {off, 3'b000};
        o_data    = '0;
        if (req.load && ram_ok) begin
            o_data = ram_rdata;
        end else if (req.load && mmio_ok) begin
            o_data = mmio_rdata;
        end
    end

    // RAM is never reset; a store coinciding with reset assertion is dropped
    always_ff @(posedge i_clk) begin
        if (i_rst_n && req.write && ram_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes[b]) begin
                    mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // Sticky error: a new error in the same cycle as a STATUS clear wins
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else if (err_ev) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign o_err = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a byte-array reference model.
// MMIO-specific checks are compiled in when DMEM_MMIO_EN is defined.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write = 1'b0;
    logic        load = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data = '0;
    logic [1:0]  memsize = 2'b00;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] gpio;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  bm [256];
    logic        err_m = 1'b0;
    logic [31:0] gpio_m = '0;
    logic [31:0] last_rd;

    data_mem_responder dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_write   (write),
        .i_load    (load),
        .i_addr    (addr),
        .i_data    (data),
        .i_memsize (memsize),
        .o_data    (rdata),
        .o_err     (err),
        .o_gpio    (gpio)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One request cycle: predict from the model, check read data, clock it, check flags
    task automatic op(input logic w, input logic l, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input string tag);
        int          n;
        bit          ram, ok, chk_rd, clr;
        logic [31:0] exp_rd;
        logic [31:0] gpio_n;
        n      = (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : (sz == 2'd3) ? 4 : 0;
        ram    = (a < 32'd4096);
        ok     = 0;
        chk_rd = 1;
        clr    = 0;
        exp_rd = '0;
        gpio_n = gpio_m;
        if (ram && n != 0 && (a % n) == 0) begin
            ok = 1;
            for (int i = 0; i < n; i++) exp_rd |= 32'(bm[8'(a + i)]) << (8 * i);
        end
`ifdef DMEM_MMIO_EN
        else if (a[31:16] == 16'hFFFF && n == 4 && a[15:4] == 12'd0 && a[1:0] == 2'd0) begin
            ok = 1;
            case (a[3:2])
                2'd0: exp_rd = gpio_m;
                2'd3: exp_rd = {31'd0, err_m};
                default: chk_rd = !l;
            endcase
            if (w && a[3:2] == 2'd0) gpio_n = d;
            if (w && a[3:2] == 2'd3 && d[0]) clr = 1;
        end
`endif
        if (!l) exp_rd = '0;
        write = w; load = l; addr = a; data = d; memsize = sz;
        #1;
        last_rd = rdata;
        if (chk_rd) check({tag, " rdata"}, rdata, exp_rd);
        @(posedge clk);
        if (w && ok && ram) for (int i = 0; i < n; i++) bm[8'(a + i)] = d[8*i +: 8];
        gpio_m = gpio_n;
        if ((w || l) && !ok) err_m = 1'b1;
        else if (clr) err_m = 1'b0;
        #1;
        write = 0; load = 0;
        check({tag, " err"}, {31'd0, err}, {31'd0, err_m});
        check({tag, " gpio"}, gpio, gpio_m);
    endtask

    initial begin
        logic [31:0] a;
        int          pick;
        #12;
        check("reset err", {31'd0, err}, 32'd0);
        check("reset gpio", gpio, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 64; i++) op(1, 0, 32'(4 * i), $urandom, 2'd3, "init");

        op(1, 0, 32'h10, 32'hDEAD_BEEF, 2'd3, "st word");
        op(0, 1, 32'h13, 32'h0, 2'd1, "ld byte");
        check("byte load 0x13", last_rd, 32'h0000_00DE);
        op(0, 1, 32'h12, 32'h0, 2'd2, "ld half");
        check("half load 0x12", last_rd, 32'h0000_DEAD);

        op(1, 0, 32'h10, 32'h1122_3344, 2'd3, "st word2");
        op(1, 0, 32'h11, 32'h0000_00AA, 2'd1, "st byte");
        op(0, 1, 32'h10, 32'h0, 2'd3, "ld merged");
        check("byte merge", last_rd, 32'h1122_AA44);

        op(1, 0, 32'h30, 32'hCAFE_0001, 2'd3, "rbw pre");
        op(1, 1, 32'h30, 32'h1234_5678, 2'd3, "rbw");
        check("read before write", last_rd, 32'hCAFE_0001);
        op(0, 1, 32'h30, 32'h0, 2'd3, "rbw post");
        check("write committed", last_rd, 32'h1234_5678);
        check("overlap no err", {31'd0, err}, 32'd0);

        op(1, 0, 32'h20, 32'h5566_7788, 2'd3, "st base");
        op(1, 0, 32'h21, 32'h0000_FFFF, 2'd2, "mis half");
        check("mis half err", {31'd0, err}, 32'd1);
        op(1, 0, 32'h22, 32'hFFFF_FFFF, 2'd3, "mis word");
        op(0, 1, 32'h21, 32'h0, 2'd2, "mis read");
        check("mis read zero", last_rd, 32'h0);
        op(0, 1, 32'h20, 32'h0, 2'd3, "ld unchanged");
        check("ram unchanged", last_rd, 32'h5566_7788);

`ifdef DMEM_MMIO_EN
        op(1, 0, 32'hFFFF_000C, 32'h1, 2'd3, "stat clr");
        check("status clear", {31'd0, err}, 32'd0);
`endif
        op(0, 1, 32'h8000_0000, 32'h0, 2'd3, "unmapped");
        check("unmapped zero", last_rd, 32'h0);
        check("unmapped err", {31'd0, err}, 32'd1);
        op(0, 1, 32'h40, 32'h0, 2'd0, "size none");

        op(1, 0, 32'hFFFF_0000, 32'h5, 2'd3, "gpio wr");
`ifdef DMEM_MMIO_EN
        check("gpio value", gpio, 32'h5);
        op(1, 0, 32'hFFFF_0000, 32'h7, 2'd1, "gpio byte");
        op(1, 0, 32'hFFFF_000C, 32'h1, 2'd3, "stat clr2");
        write = 0; load = 1; addr = 32'hFFFF_0004; memsize = 2'd3;
        force dut.u_mmio.mtime = 64'h0000_0000_FFFF_FFFF;
        #1;
        check("mtime lo", rdata, 32'hFFFF_FFFF);
        release dut.u_mmio.mtime;
        @(posedge clk);
        #1;
        load = 0;
        @(posedge clk);
        #1;
        op(0, 1, 32'hFFFF_0008, 32'h0, 2'd3, "mtime hi");
        check("mtime hi shadow", last_rd, 32'h0);
`else
        check("gpio stays zero", gpio, 32'h0);
        check("gpio wr err", {31'd0, err}, 32'd1);
`endif

        for (int k = 0; k < 400; k++) begin
            pick = $urandom_range(0, 9);
            if (pick < 7) a = 32'($urandom_range(0, 255));
            else if (pick == 7) a = 32'h0001_0000 | 32'($urandom_range(0, 255));
            else if (pick == 8) a = 32'hFFFF_0000 | 32'(4 * $urandom_range(0, 3));
            else a = 32'hFFFF_0000 | 32'($urandom_range(0, 63));
            op(1'($urandom), 1'($urandom), a, $urandom, 2'($urandom), "rand");
        end

        op(1, 0, 32'h44, 32'h0BAD_F00D, 2'd3, "pre rst");
        op(1, 0, 32'h8000_0004, 32'h0, 2'd3, "pre rst err");
        write = 1; load = 0; addr = 32'h44; data = 32'h1357_9BDF; memsize = 2'd3;
        #3;
        rst_n = 1'b0;
        #1;
        err_m = 1'b0;
        gpio_m = '0;
        check("async rst err", {31'd0, err}, 32'd0);
        check("async rst gpio", gpio, 32'h0);
        @(posedge clk);
        @(negedge clk);
        write = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        op(0, 1, 32'h44, 32'h0, 2'd3, "ram kept");
        check("ram after reset", last_rd, 32'h0BAD_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
